// File: rtl/ring_osc_freq_counter.sv
// ring_osc_freq_counter
//   Measurement stage that sits right after a ring oscillator. It enables the
//   ring and synchronizes its output into clk. It then counts rising edges
//   over a programmable window of clk cycles and reports a saturating count.
//   osc_in must stay below clk/2. The block does not check this.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   start        request a measurement (only looked at in IDLE)
//   abort        cancel a measurement in SETTLE/COUNT
//   window       window length in clk cycles, captured at accepted start
//   osc_in       raw ring output, asynchronous to clk
//   osc_en       ring enable (registered)
//   busy         high in SETTLE, COUNT and DONE
//   done         one-cycle pulse; count/overflow valid and updated
//   count        last result, held until the next done
//   overflow     last result saturated, held with count
module ring_osc_freq_counter #(
  parameter int COUNT_W       = 16,
  parameter int WIN_W         = 12,
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIN_W-1:0]   window,
  input  logic               osc_in,
  output logic               osc_en,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] count,
  output logic               overflow
);

  localparam int ST_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [WIN_W-1:0]       timer_q, timer_d;
  logic [ST_W-1:0]        settle_q, settle_d;
  logic [COUNT_W-1:0]     acc_q, acc_d;
  logic                   sticky_q, sticky_d;
  logic                   osc_en_q, osc_en_d;
  logic [COUNT_W-1:0]     count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   sync_out, rise;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~hist_q;

  always_comb begin
    // Shift toward the MSB. The MSB is the synchronized output.
    sync_d   = (sync_q << 1) | SYNC_STAGES'(osc_in);
    hist_d   = sync_out;
    state_d  = state_q;
    timer_d  = timer_q;
    settle_d = settle_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (window != '0) begin
            timer_d  = window;
            acc_d    = '0;
            sticky_d = 1'b0;
            settle_d = ST_W'(SETTLE_CYCLES);
            state_d  = SETTLE;
          end else begin
            // Empty window: report zero without ever starting the ring.
            count_d = '0;
            ovf_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      SETTLE: begin
        if (abort)                     state_d  = IDLE;
        else if (settle_q == ST_W'(1)) state_d  = COUNT;
        else                           settle_d = settle_q - ST_W'(1);
      end
      COUNT: begin
        if (rise) begin
          if (acc_q == '1) sticky_d = 1'b1;
          else             acc_d    = acc_q + COUNT_W'(1);
        end
        if (abort) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - WIN_W'(1);
          if (timer_q == WIN_W'(1)) begin
            // Publish on the edge into DONE so the result is visible with done.
            // The last window cycle's edge is included.
            state_d = DONE;
            count_d = acc_d;
            ovf_d   = sticky_d;
          end
        end
      end
      default: state_d = IDLE;  // DONE: abort is ignored here
    endcase
    osc_en_d = (state_d == SETTLE) || (state_d == COUNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      hist_q   <= 1'b0;
      timer_q  <= '0;
      settle_q <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      osc_en_q <= 1'b0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      hist_q   <= hist_d;
      timer_q  <= timer_d;
      settle_q <= settle_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      osc_en_q <= osc_en_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign osc_en   = osc_en_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule
